// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and launch-FSM state encoding
package uart_pkg;

  // Byte width shared by uart_tx, uart_rx and the buffering around them
  localparam int UART_BYTE_W = 8;

  // Launch controller states for uart_tx_fifo
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } uart_tx_fifo_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with occupancy count, reusable on tx and rx sides
module uart_sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Wr_En,
  input  logic [WIDTH-1:0] i_Wr_Data,
  input  logic             i_Rd_En,
  output logic [WIDTH-1:0] o_Rd_Data,
  output logic             o_Full,
  output logic             o_Empty,
  output logic [AW:0]      o_Count
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] r_Mem [DEPTH];
  logic [AW-1:0]    r_Wr_Ptr;
  logic [AW-1:0]    r_Rd_Ptr;
  logic [AW:0]      r_Count;

  logic w_Push;
  logic w_Pop;

  // Full blocks a push even when a pop happens in the same cycle
  assign w_Push    = i_Wr_En && !o_Full;
  assign w_Pop     = i_Rd_En && !o_Empty;
  assign o_Full    = (r_Count == DEPTH_C);
  assign o_Empty   = (r_Count == '0);
  assign o_Count   = r_Count;
  assign o_Rd_Data = r_Mem[r_Rd_Ptr];

  // Storage write; contents need no reset because count gates every read
  always_ff @(posedge i_Clock) begin
    if (w_Push) begin
      r_Mem[r_Wr_Ptr] <= i_Wr_Data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks push/pop balance
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (w_Push) begin
        r_Wr_Ptr <= r_Wr_Ptr + PTR_ONE;
      end
      if (w_Pop) begin
        r_Rd_Ptr <= r_Rd_Ptr + PTR_ONE;
      end
      case ({w_Push, w_Pop})
        2'b10:   r_Count <= r_Count + CNT_ONE;
        2'b01:   r_Count <= r_Count - CNT_ONE;
        default: r_Count <= r_Count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO plus launch controller feeding uart_tx; UART_TX_FIFO_OVERFLOW_EN enables the sticky overflow flag
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Wr_En,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [AW:0]            o_Count,
  output logic                   o_Overflow,
  input  logic                   i_Clr_Overflow,
  output logic                   o_Tx_DV,
  output logic [UART_BYTE_W-1:0] o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done
);

  uart_tx_fifo_state_t    r_State;
  logic                   r_Tx_DV;
  logic [UART_BYTE_W-1:0] r_Tx_Byte;

  logic                   w_Pop;
  logic [UART_BYTE_W-1:0] w_Head;
  logic                   w_Full;
  logic                   w_Empty;
  logic [AW:0]            w_Count;

  // Launch only from idle, with a byte queued, and never into a frame uart_tx is still sending
  assign w_Pop = (r_State == S_IDLE) && !w_Empty && !i_Tx_Active;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_BYTE_W)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Wr_En   (i_Wr_En),
    .i_Wr_Data (i_Wr_Byte),
    .i_Rd_En   (w_Pop),
    .o_Rd_Data (w_Head),
    .o_Full    (w_Full),
    .o_Empty   (w_Empty),
    .o_Count   (w_Count)
  );

  assign o_Full    = w_Full;
  assign o_Empty   = w_Empty;
  assign o_Count   = w_Count;
  assign o_Tx_DV   = r_Tx_DV;
  assign o_Tx_Byte = r_Tx_Byte;

  // Launch FSM: one DV pulse per byte, then wait for Done and one cleanup cycle
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State   <= S_IDLE;
      r_Tx_DV   <= 1'b0;
      r_Tx_Byte <= '0;
    end else begin
      case (r_State)
        S_IDLE: begin
          if (w_Pop) begin
            r_Tx_DV   <= 1'b1;
            r_Tx_Byte <= w_Head;
            r_State   <= S_WAIT_DONE;
          end else begin
            r_Tx_DV   <= 1'b0;
          end
        end
        S_WAIT_DONE: begin
          r_Tx_DV <= 1'b0;
          if (i_Tx_Done) begin
            r_State <= S_GAP;
          end
        end
        S_GAP: begin
          r_Tx_DV <= 1'b0;
          r_State <= S_IDLE;
        end
        default: begin
          r_Tx_DV <= 1'b0;
          r_State <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic r_Overflow;

  // Sticky overflow: a dropped push sets it, and wins over a same-cycle clear
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Overflow <= 1'b0;
    end else if (i_Wr_En && w_Full) begin
      r_Overflow <= 1'b1;
    end else if (i_Clr_Overflow) begin
      r_Overflow <= 1'b0;
    end
  end

  assign o_Overflow = r_Overflow;
`else
  logic w_unused_clr;

  assign w_unused_clr = i_Clr_Overflow;
  assign o_Overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo with a behavioural uart_tx stand-in
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          i_Clock        = 1'b0;
  logic          i_Reset        = 1'b1;
  logic          i_Wr_En        = 1'b0;
  logic [7:0]    i_Wr_Byte      = 8'h00;
  logic          i_Clr_Overflow = 1'b0;
  logic          i_Tx_Active    = 1'b0;
  logic          i_Tx_Done      = 1'b0;
  logic          o_Full;
  logic          o_Empty;
  logic [AW:0]   o_Count;
  logic          o_Overflow;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_Wr_En        (i_Wr_En),
    .i_Wr_Byte      (i_Wr_Byte),
    .o_Full         (o_Full),
    .o_Empty        (o_Empty),
    .o_Count        (o_Count),
    .o_Overflow     (o_Overflow),
    .i_Clr_Overflow (i_Clr_Overflow),
    .o_Tx_DV        (o_Tx_DV),
    .o_Tx_Byte      (o_Tx_Byte),
    .i_Tx_Active    (i_Tx_Active),
    .i_Tx_Done      (i_Tx_Done)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting in the FIFO, launch bookkeeping, overflow flag
  logic [7:0] mq[$];
  bit         outstanding = 0;
  int         idle_from   = 0;
  int         edge_n      = 0;
  bit         m_ovf       = 0;
  logic [7:0] exp_byte    = 8'h00;

  // uart_tx stand-in state
  bit tx_active = 0;
  bit tx_done   = 0;
  bit hold      = 0;
  int tx_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // Monitor: sample inputs at the edge, predict the post-edge state, compare 1 time unit later
  always @(posedge i_Clock) begin
    logic       p_wr, p_rst, p_clr, p_act, p_done;
    logic [7:0] p_byte;
    bit         exp_dv, full_before;
    p_wr   = i_Wr_En;
    p_byte = i_Wr_Byte;
    p_rst  = i_Reset;
    p_clr  = i_Clr_Overflow;
    p_act  = i_Tx_Active;
    p_done = i_Tx_Done;
    #1;
    edge_n++;
    exp_dv = 0;
    if (p_rst) begin
      mq.delete();
      outstanding = 0;
      idle_from   = 0;
      m_ovf       = 0;
      exp_byte    = 8'h00;
    end else begin
      full_before = (mq.size() == DEPTH);
      exp_dv = !outstanding && (edge_n >= idle_from) && (mq.size() != 0) && !p_act;
      if (p_done && outstanding) begin
        outstanding = 0;
        idle_from   = edge_n + 2;
      end
      if (exp_dv) begin
        exp_byte    = mq.pop_front();
        outstanding = 1;
      end
      if (p_wr && !full_before) mq.push_back(p_byte);
      if (p_wr && full_before) m_ovf = 1;
      else if (p_clr)          m_ovf = 0;
    end
    chk("tx_dv",   o_Tx_DV,   exp_dv);
    chk("tx_byte", o_Tx_Byte, exp_byte);
    chk("count",   o_Count,   mq.size());
    chk("empty",   o_Empty,   mq.size() == 0);
    chk("full",    o_Full,    mq.size() == DEPTH);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("overflow", o_Overflow, m_ovf);
`else
    chk("overflow", o_Overflow, 0);
`endif
    chk("dv_while_active", o_Tx_DV && (tx_active || hold), 0);
    if (tx_done) tx_done = 0;
    if (o_Tx_DV) begin
      tx_active = 1;
      tx_cnt    = $urandom_range(1, 12);
    end else if (tx_active) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_active = 0;
        tx_done   = 1;
      end
    end
    i_Tx_Active = tx_active || hold;
    i_Tx_Done   = tx_done;
  end

  task automatic cyc(input logic wr, input logic [7:0] b);
    i_Wr_En   = wr;
    i_Wr_Byte = b;
    @(negedge i_Clock);
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || outstanding || tx_active) && n < 3000) begin
      cyc(1'b0, 8'h00);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d queued expected 0", mq.size());
    end
    repeat (3) cyc(1'b0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge i_Clock);
    i_Reset = 1'b1;
    repeat (3) cyc(1'b0, 8'h00);
    i_Reset = 1'b0;
    cyc(1'b0, 8'h00);

    // Single byte
    cyc(1'b1, 8'hAB);
    repeat (30) cyc(1'b0, 8'h00);
    drain();

    // Burst of five
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i));
    drain();

    // Full and overflow with uart_tx held busy
    hold = 1;
    i_Tx_Active = 1'b1;
    cyc(1'b0, 8'h00);
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h80 + i));
    repeat (2) cyc(1'b0, 8'h00);
    i_Clr_Overflow = 1'b1;
    cyc(1'b1, 8'hEE);
    cyc(1'b0, 8'h00);
    i_Clr_Overflow = 1'b0;
    cyc(1'b0, 8'h00);
    hold = 0;
    i_Tx_Active = tx_active;
    drain();

    // Wrap-around: 40 bytes in mixed bursts
    begin
      int v = 0;
      while (v < 40) begin
        int len = $urandom_range(1, 6);
        for (int k = 0; k < len && v < 40; k++) begin
          cyc(1'b1, 8'(v));
          v++;
        end
        repeat ($urandom_range(0, 30)) cyc(1'b0, 8'h00);
      end
    end
    drain();

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      i_Clr_Overflow = ($urandom_range(0, 49) == 0);
      i_Reset        = ($urandom_range(0, 399) == 0);
      cyc(($urandom_range(0, 2) == 0), 8'($urandom));
    end
    i_Clr_Overflow = 1'b0;
    i_Reset        = 1'b0;
    drain();

    // Reset mid-frame with bytes queued, then push while uart_tx finishes its frame
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i));
    cyc(1'b0, 8'h00);
    i_Reset = 1'b1;
    cyc(1'b0, 8'h00);
    i_Reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hD0 + i));
    drain();

    repeat (5) cyc(1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
